// File: rtl/div_seq.sv
// div_seq: multicycle radix-2 restoring DIV/DIVU sequencer; `define DIV_EARLY_EXIT_EN enables the |b|>|a| early exit
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic             annul_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             stall_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, DIVZERO, ON, DONE} state_t;
   state_t           r_state, w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem, r_quo, r_div, r_a, r_lo, r_hi;
   logic             r_neg_q, r_neg_r;
   logic             w_accept, w_bzero, w_early, w_last, w_ge;
   logic [WIDTH-1:0] w_a_mag, w_b_mag, w_rem_n, w_quo_n, w_lo_fin, w_hi_fin;
   logic [WIDTH:0]   w_trial;

   assign w_accept = (r_state == IDLE) && start_i && !annul_i;
   assign w_bzero  = (b_i == '0);
   assign w_a_mag  = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
   assign w_b_mag  = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
`ifdef DIV_EARLY_EXIT_EN
   assign w_early  = !w_bzero && (w_b_mag > w_a_mag);
`else
   assign w_early  = 1'b0;
`endif
   // one restoring step: shift the next dividend bit into the partial remainder and trial-subtract
   assign w_trial  = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_div};
   assign w_ge     = !w_trial[WIDTH];
   assign w_rem_n  = w_ge ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
   assign w_quo_n  = {r_quo[WIDTH-2:0], w_ge};
   assign w_lo_fin = r_neg_q ? -w_quo_n : w_quo_n;
   assign w_hi_fin = r_neg_r ? -w_rem_n : w_rem_n;
   assign w_last   = (r_cnt == CW'(WIDTH - 1));
   assign lo_o     = r_lo;
   assign hi_o     = r_hi;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // next state and handshake outputs
   always_comb begin
      w_next  = r_state;
      stall_o = 1'b0;
      ready_o = 1'b0;
      case (r_state)
         IDLE: begin
            stall_o = w_accept;
            if (w_accept) w_next = w_bzero ? DIVZERO : (w_early ? DONE : ON);
         end
         DIVZERO: begin
            stall_o = 1'b1;
            w_next  = annul_i ? IDLE : DONE;
         end
         ON: begin
            stall_o = 1'b1;
            w_next  = annul_i ? IDLE : (w_last ? DONE : ON);
         end
         default: begin
            ready_o = 1'b1;
            w_next  = IDLE;
         end
      endcase
   end

   // operand capture, iteration datapath and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_div   <= '0;
         r_a     <= '0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
            r_a     <= a_i;
            r_neg_q <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            r_neg_r <= signed_i && a_i[WIDTH-1];
            if (w_early) begin
               r_lo <= '0;
               r_hi <= a_i;
            end
         end
         if (r_state == ON) begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            r_cnt <= r_cnt + CW'(1);
            if (w_last && !annul_i) begin
               r_lo <= w_lo_fin;
               r_hi <= w_hi_fin;
            end
         end
         if (r_state == DIVZERO && !annul_i) begin
            r_lo <= '1;
            r_hi <= r_a;
         end
      end
   end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq covering latency, sign fix-up, divide-by-zero, annul and reset
module tb_div_seq;
   localparam int W = 32;
`ifdef DIV_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   logic         clk = 1'b0;
   logic         rst, start_i, signed_i, annul_i;
   logic [W-1:0] a_i, b_i;
   logic         stall_o, ready_o;
   logic [W-1:0] lo_o, hi_o;

   typedef struct {logic [W-1:0] lo; logic [W-1:0] hi; int cyc;} exp_t;
   exp_t sb[$];
   exp_t e;
   int n_cmp = 0, n_err = 0;
   int o_rdy, o_rcnt, o_scnt, o_slast;
   logic [W-1:0] o_lo, o_hi, o_nlo, o_nhi, o_end_lo, o_end_hi, o_rs_lo, o_rs_hi;
   logic o_rs_stall, o_rs_rdy;

   div_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i), .annul_i(annul_i),
      .a_i(a_i), .b_i(b_i), .stall_o(stall_o), .ready_o(ready_o), .lo_o(lo_o), .hi_o(hi_o)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
      return (s && x[W-1]) ? -x : x;
   endfunction

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      exp_t r;
      longint sa, sbv, q, m;
      if (b == '0) begin
         r.lo = '1; r.hi = a; r.cyc = 2;
      end else if (!s) begin
         r.lo = a / b; r.hi = a % b; r.cyc = 33;
      end else begin
         sa = longint'($signed(a)); sbv = longint'($signed(b));
         q = sa / sbv; m = sa % sbv;
         r.lo = q[W-1:0]; r.hi = m[W-1:0]; r.cyc = 33;
      end
      if (EARLY && b != '0 && mag(b, s) > mag(a, s)) begin
         r.lo = '0; r.hi = a; r.cyc = 1;
      end
      return r;
   endfunction

   // drives one operation starting at cycle 0 and records what the DUT showed; no checking here
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int annul_at, input int rst_at, input int maxc, input bit hold);
      o_rdy = -1; o_rcnt = 0; o_scnt = 0; o_slast = -1;
      @(negedge clk);
      a_i = a; b_i = b; signed_i = s; start_i = 1'b1;
      for (int c = 0; c < maxc; c++) begin
         if (c > 0) begin
            @(negedge clk);
            if (!hold || o_rdy >= 0) start_i = 1'b0;
            if (hold) begin a_i = $urandom; b_i = $urandom; signed_i = ~s; end
         end
         annul_i = (c == annul_at);
         if (c == rst_at) rst = 1'b1;
         #1;
         if (stall_o) begin o_scnt++; o_slast = c; end
         if (ready_o) begin
            o_rcnt++;
            if (o_rdy < 0) begin o_rdy = c; o_lo = lo_o; o_hi = hi_o; end
         end
         if (c == rst_at) begin
            o_rs_lo = lo_o; o_rs_hi = hi_o; o_rs_stall = stall_o; o_rs_rdy = ready_o;
            rst = 1'b0;
         end
         if (o_rdy >= 0 && c == o_rdy + 1) begin o_nlo = lo_o; o_nhi = hi_o; break; end
      end
      start_i = 1'b0; annul_i = 1'b0;
      o_end_lo = lo_o; o_end_hi = hi_o;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_o); end
      n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready_o); end
      n_cmp++; if (lo_o !== '0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo_o); end
      n_cmp++; if (hi_o !== '0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi_o); end
      rst = 1'b0;
   endtask

   task automatic test_divu();
      sb.push_back('{lo: 32'd14, hi: 32'd2, cyc: 33});
      do_op(32'd100, 32'd7, 1'b0, -1, -1, 40, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (o_rdy !== e.cyc) begin n_err++; $display("FAIL divu_ready_cycle: got %0d want %0d", o_rdy, e.cyc); end
      n_cmp++; if (o_rcnt !== 1) begin n_err++; $display("FAIL divu_ready_pulses: got %0d want 1", o_rcnt); end
      n_cmp++; if (o_scnt !== 33) begin n_err++; $display("FAIL divu_stall_cycles: got %0d want 33", o_scnt); end
      n_cmp++; if (o_slast !== 32) begin n_err++; $display("FAIL divu_stall_last: got %0d want 32", o_slast); end
      n_cmp++; if (o_lo !== e.lo) begin n_err++; $display("FAIL divu_lo: got %h want %h", o_lo, e.lo); end
      n_cmp++; if (o_hi !== e.hi) begin n_err++; $display("FAIL divu_hi: got %h want %h", o_hi, e.hi); end
      n_cmp++; if (o_nlo !== e.lo || o_nhi !== e.hi) begin n_err++; $display("FAIL divu_hold: got %h/%h want %h/%h", o_nlo, o_nhi, e.lo, e.hi); end
   endtask

   task automatic test_signed();
      sb.push_back('{lo: 32'hFFFF_FFFD, hi: 32'hFFFF_FFFF, cyc: 33});
      do_op(32'hFFFF_FFF9, 32'd2, 1'b1, -1, -1, 40, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (o_rdy !== e.cyc) begin n_err++; $display("FAIL div_neg_ready_cycle: got %0d want %0d", o_rdy, e.cyc); end
      n_cmp++; if (o_lo !== e.lo) begin n_err++; $display("FAIL div_neg_lo: got %h want %h", o_lo, e.lo); end
      n_cmp++; if (o_hi !== e.hi) begin n_err++; $display("FAIL div_neg_hi: got %h want %h", o_hi, e.hi); end
      sb.push_back('{lo: 32'h8000_0000, hi: 32'h0, cyc: 33});
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1, 40, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (o_lo !== e.lo) begin n_err++; $display("FAIL div_ovf_lo: got %h want %h", o_lo, e.lo); end
      n_cmp++; if (o_hi !== e.hi) begin n_err++; $display("FAIL div_ovf_hi: got %h want %h", o_hi, e.hi); end
      sb.push_back('{lo: 32'hFFFF_FFFE, hi: 32'h1, cyc: 33});
      do_op(32'd7, 32'hFFFF_FFFD, 1'b1, -1, -1, 40, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (o_lo !== e.lo || o_hi !== e.hi) begin n_err++; $display("FAIL div_negb: got %h/%h want %h/%h", o_lo, o_hi, e.lo, e.hi); end
   endtask

   task automatic test_divzero();
      sb.push_back('{lo: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFB, cyc: 2});
      do_op(32'hFFFF_FFFB, 32'd0, 1'b1, -1, -1, 40, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (o_lo !== e.lo || o_hi !== e.hi) begin n_err++; $display("FAIL divz_signed: got %h/%h want %h/%h", o_lo, o_hi, e.lo, e.hi); end
      sb.push_back('{lo: 32'hFFFF_FFFF, hi: 32'd5, cyc: 2});
      do_op(32'd5, 32'd0, 1'b0, -1, -1, 40, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (o_rdy !== e.cyc) begin n_err++; $display("FAIL divz_ready_cycle: got %0d want %0d", o_rdy, e.cyc); end
      n_cmp++; if (o_scnt !== 2) begin n_err++; $display("FAIL divz_stall_cycles: got %0d want 2", o_scnt); end
      n_cmp++; if (o_lo !== e.lo) begin n_err++; $display("FAIL divz_lo: got %h want %h", o_lo, e.lo); end
      n_cmp++; if (o_hi !== e.hi) begin n_err++; $display("FAIL divz_hi: got %h want %h", o_hi, e.hi); end
   endtask

   task automatic test_annul();
      do_op(32'd50, 32'd5, 1'b0, 0, -1, 3, 1'b0);
      n_cmp++; if (o_scnt !== 0) begin n_err++; $display("FAIL annul_start_stall: got %0d want 0", o_scnt); end
      n_cmp++; if (o_rdy !== -1) begin n_err++; $display("FAIL annul_start_ready: got %0d want -1", o_rdy); end
      do_op(32'd100, 32'd7, 1'b0, 10, -1, 12, 1'b0);
      n_cmp++; if (o_rdy !== -1) begin n_err++; $display("FAIL annul_ready: got %0d want -1", o_rdy); end
      n_cmp++; if (o_slast !== 10) begin n_err++; $display("FAIL annul_stall_last: got %0d want 10", o_slast); end
      n_cmp++; if (o_end_lo !== 32'hFFFF_FFFF || o_end_hi !== 32'd5) begin n_err++; $display("FAIL annul_keep: got %h/%h want ffffffff/00000005", o_end_lo, o_end_hi); end
      sb.push_back('{lo: 32'd3, hi: 32'd0, cyc: 45});
      do_op(32'd9, 32'd3, 1'b0, -1, -1, 40, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (12 + o_rdy !== e.cyc) begin n_err++; $display("FAIL annul_next_cycle: got %0d want %0d", 12 + o_rdy, e.cyc); end
      n_cmp++; if (o_lo !== e.lo || o_hi !== e.hi) begin n_err++; $display("FAIL annul_next: got %h/%h want %h/%h", o_lo, o_hi, e.lo, e.hi); end
   endtask

   task automatic test_busy_start();
      sb.push_back('{lo: 32'd111, hi: 32'd1, cyc: 33});
      do_op(32'd1000, 32'd9, 1'b0, -1, -1, 40, 1'b1);
      e = sb.pop_front();
      n_cmp++; if (o_rdy !== e.cyc) begin n_err++; $display("FAIL busy_ready_cycle: got %0d want %0d", o_rdy, e.cyc); end
      n_cmp++; if (o_rcnt !== 1) begin n_err++; $display("FAIL busy_ready_pulses: got %0d want 1", o_rcnt); end
      n_cmp++; if (o_lo !== e.lo || o_hi !== e.hi) begin n_err++; $display("FAIL busy_result: got %h/%h want %h/%h", o_lo, o_hi, e.lo, e.hi); end
   endtask

   task automatic test_rst_mid();
      do_op(32'd100, 32'd7, 1'b0, -1, 20, 30, 1'b0);
      n_cmp++; if (o_rs_lo !== '0 || o_rs_hi !== '0) begin n_err++; $display("FAIL rst_mid_result: got %h/%h want 0/0", o_rs_lo, o_rs_hi); end
      n_cmp++; if (o_rs_stall !== 1'b0 || o_rs_rdy !== 1'b0) begin n_err++; $display("FAIL rst_mid_ctrl: got %b/%b want 0/0", o_rs_stall, o_rs_rdy); end
      n_cmp++; if (o_rdy !== -1) begin n_err++; $display("FAIL rst_mid_ready: got %0d want -1", o_rdy); end
      n_cmp++; if (o_slast !== 19) begin n_err++; $display("FAIL rst_mid_stall_last: got %0d want 19", o_slast); end
   endtask

   task automatic test_early_exit();
      sb.push_back('{lo: 32'd0, hi: 32'd3, cyc: EARLY ? 1 : 33});
      do_op(32'd3, 32'd10, 1'b0, -1, -1, 40, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (o_rdy !== e.cyc) begin n_err++; $display("FAIL early_ready_cycle: got %0d want %0d", o_rdy, e.cyc); end
      n_cmp++; if (o_scnt !== (EARLY ? 1 : 33)) begin n_err++; $display("FAIL early_stall_cycles: got %0d want %0d", o_scnt, EARLY ? 1 : 33); end
      n_cmp++; if (o_lo !== e.lo || o_hi !== e.hi) begin n_err++; $display("FAIL early_result: got %h/%h want %h/%h", o_lo, o_hi, e.lo, e.hi); end
      sb.push_back(model(32'hFFFF_FFFD, 32'd10, 1'b1));
      do_op(32'hFFFF_FFFD, 32'd10, 1'b1, -1, -1, 40, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (o_rdy !== e.cyc || o_lo !== e.lo || o_hi !== e.hi) begin n_err++; $display("FAIL early_signed: got %0d %h/%h want %0d %h/%h", o_rdy, o_lo, o_hi, e.cyc, e.lo, e.hi); end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      logic s;
      for (int k = 0; k < 8; k++) begin
         a = $urandom;
         b = ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 20)) : W'($urandom);
         if (k == 5) b = '0;
         if (k == 6) a = W'($urandom_range(0, 50));
         s = 1'($urandom_range(0, 1));
         sb.push_back(model(a, b, s));
         do_op(a, b, s, -1, -1, 40, 1'b0);
         e = sb.pop_front();
         n_cmp++; if (o_rdy !== e.cyc || o_lo !== e.lo || o_hi !== e.hi) begin n_err++; $display("FAIL random_%0d (%h/%h s=%b): got %0d %h/%h want %0d %h/%h", k, a, b, s, o_rdy, o_lo, o_hi, e.cyc, e.lo, e.hi); end
      end
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0; a_i = '0; b_i = '0;
      test_reset();
      test_divu();
      test_signed();
      test_divzero();
      test_annul();
      test_busy_start();
      test_rst_mid();
      test_early_exit();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
